// File: rtl/icache_line_fetcher_if.sv
// Line-read and memory-bus signal bundle for icache_line_fetcher.
// The slave modport is the fetcher's view; master is the replacer/bus side.
`timescale 1ns/1ps
interface icache_line_fetcher_if #(
    parameter int LINE_WIDTH     = 128,
    parameter int BUS_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 28
);
    localparam int BUS_ADDR_WIDTH = MEM_ADDR_WIDTH + $clog2(LINE_WIDTH/8);

    logic                      memReadEnable;
    logic [MEM_ADDR_WIDTH-1:0] memAddr;
    logic                      memReadDone;
    logic [LINE_WIDTH-1:0]     memReadValue;
    logic                      busReq;
    logic [BUS_ADDR_WIDTH-1:0] busAddr;
    logic                      busGrant;
    logic                      busReadValid;
    logic [BUS_WIDTH-1:0]      busReadData;

    modport slave (
        input  memReadEnable, memAddr, busGrant, busReadValid, busReadData,
        output memReadDone, memReadValue, busReq, busAddr
    );

    modport master (
        output memReadEnable, memAddr, busGrant, busReadValid, busReadData,
        input  memReadDone, memReadValue, busReq, busAddr
    );
endinterface

// File: rtl/icache_line_fetcher.sv
// ICache line fetcher: reads one cache line as BEATS sequential bus beats,
// assembles them little-endian and returns the line with a one-cycle done pulse.
`timescale 1ns/1ps
module icache_line_fetcher #(
    parameter int LINE_WIDTH     = 128,
    parameter int BUS_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    icache_line_fetcher_if.slave  fetch_if
);
    localparam int BEATS          = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTE_OFF       = $clog2(BUS_WIDTH/8);
    localparam int LINE_OFF       = $clog2(LINE_WIDTH/8);
    localparam int BUS_ADDR_WIDTH = MEM_ADDR_WIDTH + LINE_OFF;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA, RESPOND} state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [BEAT_W-1:0]         beat_q;
    logic                      abort_q;
    logic [LINE_WIDTH-1:0]     line_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: enable dropping in Request/WaitData abandons the fetch without a done pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (fetch_if.memReadEnable) state_d = REQUEST;
            REQUEST: begin
                if (!fetch_if.memReadEnable) state_d = IDLE;
                else if (fetch_if.busGrant)  state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (fetch_if.busReadValid) begin
                    if (abort_q || !fetch_if.memReadEnable) state_d = IDLE;
                    else if (beat_q == LAST_BEAT)           state_d = RESPOND;
                    else                                    state_d = REQUEST;
                end
            end
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Datapath: latch request address, count beats, assemble the line, track aborts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            beat_q  <= '0;
            abort_q <= 1'b0;
            line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_if.memReadEnable) begin
                        addr_q  <= fetch_if.memAddr;
                        beat_q  <= '0;
                        abort_q <= 1'b0;
                    end
                end
                WAIT_DATA: begin
                    if (!fetch_if.memReadEnable) abort_q <= 1'b1;
                    if (fetch_if.busReadValid) begin
                        line_q[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH] <= fetch_if.busReadData;
                        if (beat_q != LAST_BEAT) beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; cleared at once by the asynchronous reset
    always_comb begin
        fetch_if.busReq      = (state_q == REQUEST);
        fetch_if.memReadDone = (state_q == RESPOND);
    end

    assign fetch_if.busAddr      = (BUS_ADDR_WIDTH'(addr_q) << LINE_OFF)
                                 | (BUS_ADDR_WIDTH'(beat_q) << BYTE_OFF);
    assign fetch_if.memReadValue = line_q;

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Self-checking bench for icache_line_fetcher: acts as replacer and bus,
// scoreboards beat addresses and assembled lines.
`timescale 1ns/1ps
module tb_icache_line_fetcher;
    localparam int LW = 128;
    localparam int BW = 32;
    localparam int AW = 28;

    logic clk;
    logic rst;

    icache_line_fetcher_if #(.LINE_WIDTH(LW), .BUS_WIDTH(BW), .MEM_ADDR_WIDTH(AW)) fif ();

    icache_line_fetcher #(.LINE_WIDTH(LW), .BUS_WIDTH(BW), .MEM_ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_if (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned now_cyc = 0;
    int unsigned done_at = 0;
    int unsigned first_req_at = 0;
    logic [LW-1:0] last_line = '0;

    logic [31:0]  addr_sb[$];
    logic [LW-1:0] line_sb[$];

    logic [BW-1:0] data[4];
    int gdly[4];
    int vdly[4];

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        now_cyc++;
    endtask

    task automatic clear_delays();
        for (int i = 0; i < 4; i++) begin
            gdly[i] = 0;
            vdly[i] = 0;
        end
    endtask

    // One line fetch seen from the replacer and the bus. abort_beat/rst_beat < 0 disable those events.
    task automatic fetch(input logic [AW-1:0] addr, input int abort_beat, input int rst_beat,
                         input int exp_done);
        int cyc;
        int beat;
        int wcnt;
        int phase;
        int post;
        bit fin;
        logic [LW-1:0] exp_line;
        fif.memAddr = addr;
        fif.memReadEnable = 1'b1;
        for (int b = 0; b < 4; b++) addr_sb.push_back({addr, 4'h0} + 32'(b*4));
        if (abort_beat < 0 && rst_beat < 0) line_sb.push_back({data[3], data[2], data[1], data[0]});
        cyc = 0; beat = 0; wcnt = gdly[0]; phase = 0; post = 0; fin = 0;
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
            fif.busGrant = 1'b0;
            fif.busReadValid = 1'b0;
            case (phase)
                0: begin
                    check("busReq_high", fif.busReq, 1);
                    check("busAddr", fif.busAddr, addr_sb[0]);
                    if (beat == 0 && cyc == 1) first_req_at = now_cyc;
                    if (beat == rst_beat) begin
                        rst = 1'b0;
                        #1;
                        check("rst_busReq", fif.busReq, 0);
                        check("rst_done", fif.memReadDone, 0);
                        check("rst_line", fif.memReadValue, 0);
                        check("rst_busAddr", fif.busAddr, 0);
                        fif.memReadEnable = 1'b0;
                        tick();
                        tick();
                        rst = 1'b1;
                        tick();
                        addr_sb.delete();
                        fin = 1;
                    end else if (wcnt == 0) begin
                        fif.busGrant = 1'b1;
                        void'(addr_sb.pop_front());
                        phase = 1;
                        wcnt = vdly[beat];
                    end else begin
                        wcnt--;
                    end
                end
                1: begin
                    check("busReq_low", fif.busReq, 0);
                    check("no_early_done", fif.memReadDone, 0);
                    if (beat == abort_beat) fif.memReadEnable = 1'b0;
                    if (wcnt == 0) begin
                        fif.busReadValid = 1'b1;
                        fif.busReadData = data[beat];
                        beat++;
                        if (beat - 1 == abort_beat) phase = 3;
                        else if (beat == 4) phase = 2;
                        else begin
                            phase = 0;
                            wcnt = gdly[beat];
                        end
                    end else begin
                        wcnt--;
                    end
                end
                2: begin
                    if (fif.memReadDone) begin
                        exp_line = line_sb.pop_front();
                        check("done_cycle", cyc, exp_done);
                        check("line", fif.memReadValue, exp_line);
                        last_line = exp_line;
                        done_at = now_cyc;
                        fif.memReadEnable = 1'b0;
                        tick();
                        check("done_single", fif.memReadDone, 0);
                        check("line_hold", fif.memReadValue, exp_line);
                        fin = 1;
                    end
                end
                default: begin
                    check("abort_busReq", fif.busReq, 0);
                    check("abort_done", fif.memReadDone, 0);
                    post++;
                    if (post == 4) begin
                        addr_sb.delete();
                        fin = 1;
                    end
                end
            endcase
        end
        fif.busGrant = 1'b0;
        fif.busReadValid = 1'b0;
        if (!fin) begin
            check("timeout", 0, 1);
            fif.memReadEnable = 1'b0;
            addr_sb.delete();
            line_sb.delete();
        end
    endtask

    initial begin
        int unsigned prev_done;
        rst = 1'b0;
        fif.memReadEnable = 1'b0;
        fif.memAddr = '0;
        fif.busGrant = 1'b0;
        fif.busReadValid = 1'b0;
        fif.busReadData = '0;
        clear_delays();
        tick();
        tick();
        check("reset_busReq", fif.busReq, 0);
        check("reset_done", fif.memReadDone, 0);
        check("reset_busAddr", fif.busAddr, 0);
        check("reset_line", fif.memReadValue, 0);
        rst = 1'b1;
        tick();

        // Basic zero-wait fetch
        data[0] = 32'h11111111; data[1] = 32'h22222222;
        data[2] = 32'h33333333; data[3] = 32'h44444444;
        fetch(28'h0000123, -1, -1, 9);
        check("basic_line_const", fif.memReadValue, 128'h44444444_33333333_22222222_11111111);

        // Grant stalled 3 cycles on beat 1, data stalled 2 cycles on beat 2
        data[0] = 32'hA0A0A0A0; data[1] = 32'hB1B1B1B1;
        data[2] = 32'hC2C2C2C2; data[3] = 32'hD3D3D3D3;
        gdly[1] = 3;
        vdly[2] = 2;
        fetch(28'h0ABCDE0, -1, -1, 14);
        clear_delays();

        // Back-to-back at top of address space
        prev_done = done_at;
        data[0] = 32'hDEADBEEF; data[1] = 32'h01234567;
        data[2] = 32'h89ABCDEF; data[3] = 32'hFEDCBA98;
        fetch(28'hFFFFFFF, -1, -1, 9);
        check("b2b_gap", first_req_at - prev_done, 2);

        // Spurious bus strobes while idle
        for (int i = 0; i < 3; i++) begin
            fif.busGrant = 1'b1;
            fif.busReadValid = 1'b1;
            fif.busReadData = $urandom;
            tick();
            check("spur_busReq", fif.busReq, 0);
            check("spur_done", fif.memReadDone, 0);
            check("spur_line", fif.memReadValue, last_line);
        end
        fif.busGrant = 1'b0;
        fif.busReadValid = 1'b0;
        tick();
        check("spur_line_after", fif.memReadValue, last_line);

        // Abort during WaitData of beat 2, then a normal fetch
        data[0] = 32'h0F0F0F0F; data[1] = 32'h1E1E1E1E;
        data[2] = 32'h2D2D2D2D; data[3] = 32'h3C3C3C3C;
        vdly[2] = 1;
        fetch(28'h0000777, 2, -1, 0);
        clear_delays();
        data[0] = 32'h55555555; data[1] = 32'h66666666;
        data[2] = 32'h77777777; data[3] = 32'h88888888;
        fetch(28'h0000456, -1, -1, 9);

        // Asynchronous reset in the middle of beat 1, then a fresh fetch
        fetch(28'h0000999, -1, 1, 0);
        data[0] = 32'h9ABCDEF0; data[1] = 32'h13579BDF;
        data[2] = 32'h2468ACE0; data[3] = 32'h0C0FFEE0;
        fetch(28'h0000321, -1, -1, 9);
        check("sb_empty", line_sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
